m_wb_stage_buffer: RTL and testbench

//  Parametrised MEM->WB pipeline buffer. Replaces the single-entry stall-based MEM/WB register.

---
 rtl/m_wb_pkg.sv | 25 ++
 rtl/fifo_ptr_ctrl.sv | 71 +++++++
 rtl/m_wb_stage_buffer.sv | 102 ++++++++++
 tb/tb_m_wb_stage_buffer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/m_wb_pkg.sv
// MEM->WB stage buffer shared types: payload struct, width constants, pointer-width helper.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package m_wb_pkg;

  // Core-wide widths. The top-level parameters default to these values.
  localparam int MWB_WORD_SIZE       = 32;
  localparam int MWB_INSTR_TYPE_SZ   = 4;
  localparam int MWB_ROB_ENTRY_WIDTH = 5;

  typedef struct packed {
    logic [MWB_INSTR_TYPE_SZ-1:0]   instr_type;
    logic [MWB_WORD_SIZE-1:0]       pc;
    logic                           exception;
    logic [MWB_WORD_SIZE-1:0]       vaddr_exc;
    logic [MWB_WORD_SIZE-1:0]       alu_result;
    logic [MWB_ROB_ENTRY_WIDTH-1:0] rob_id;
  } m_wb_payload_t;

  // Pointer width for a power-of-two FIFO of the given depth.
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer and occupancy control for a DEPTH-entry in-order FIFO.
// Latency: state updates on the clock edge following push/pop/flush.
// Backpressure: push ignored while full, pop ignored while empty; flush overrides both.
// Ports: clk, rst_n (async active-low), push/pop/flush in; rd_ptr/wr_ptr/count/full/empty out.
module fifo_ptr_ctrl
  import m_wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  // Qualify locally so a caller can never overflow or underflow the count.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap modulo DEPTH through natural overflow (DEPTH is a power of two).
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_ptr = rd_ptr_q;
  assign wr_ptr = wr_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/m_wb_stage_buffer.sv
// MEM->WB pipeline buffer: DEPTH-entry in-order FIFO with valid/ready on both sides and full flush.
// Latency: entry pushed at edge N appears on out_* after edge N; no same-cycle pass-through.
// Backpressure: in_ready = !full (state-only, no path from out_ready); head holds while out_ready=0.
// Ports: clk, reset (async active-low), flush; in_valid/in_ready + 6 in_* payload fields;
//        out_valid/out_ready + 6 out_* payload fields; count (occupied entries).
module m_wb_stage_buffer
  import m_wb_pkg::*;
#(
  parameter  int WORD_SIZE       = MWB_WORD_SIZE,
  parameter  int INSTR_TYPE_SZ   = MWB_INSTR_TYPE_SZ,
  parameter  int ROB_ENTRY_WIDTH = MWB_ROB_ENTRY_WIDTH,
  parameter  int DEPTH           = 2,
  localparam int PTR_W           = ptr_w(DEPTH),
  localparam int CNT_W           = PTR_W + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_TYPE_SZ-1:0]   in_instruction_type,
  input  logic [WORD_SIZE-1:0]       in_pc,
  input  logic                       in_exception,
  input  logic [WORD_SIZE-1:0]       in_virtual_addr_exception,
  input  logic [WORD_SIZE-1:0]       in_alu_result,
  input  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_TYPE_SZ-1:0]   out_instruction_type,
  output logic [WORD_SIZE-1:0]       out_pc,
  output logic                       out_exception,
  output logic [WORD_SIZE-1:0]       out_virtual_addr_exception,
  output logic [WORD_SIZE-1:0]       out_alu_result,
  output logic [ROB_ENTRY_WIDTH-1:0] out_rob_id,
  output logic [CNT_W-1:0]           count
);

  // The storage struct has fixed widths, so the parameters must agree with the package.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("m_wb_stage_buffer: DEPTH must be a power of two >= 2");
  end
  if (WORD_SIZE != MWB_WORD_SIZE || INSTR_TYPE_SZ != MWB_INSTR_TYPE_SZ ||
      ROB_ENTRY_WIDTH != MWB_ROB_ENTRY_WIDTH) begin : g_bad_width
    $error("m_wb_stage_buffer: payload widths differ from m_wb_pkg");
  end

  m_wb_payload_t    storage_q [DEPTH];
  m_wb_payload_t    in_payload, head;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             full, empty, push, pop;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .clk    (clk),
    .rst_n  (reset),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .rd_ptr (rd_ptr),
    .wr_ptr (wr_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign in_payload = '{instr_type: in_instruction_type,
                        pc:         in_pc,
                        exception:  in_exception,
                        vaddr_exc:  in_virtual_addr_exception,
                        alu_result: in_alu_result,
                        rob_id:     in_rob_id};

  // Reset clears storage so the head reads zero; flush leaves contents in place.
  // A flushed push is dropped, so it never writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) storage_q[i] <= '0;
    end else if (push && !flush) begin
      storage_q[wr_ptr] <= in_payload;
    end
  end

  assign head                       = storage_q[rd_ptr];
  assign out_instruction_type       = head.instr_type;
  assign out_pc                     = head.pc;
  assign out_exception              = head.exception;
  assign out_virtual_addr_exception = head.vaddr_exc;
  assign out_alu_result             = head.alu_result;
  assign out_rob_id                 = head.rob_id;

  // A stalled head must hold; flush legitimately moves rd_ptr, so it is excluded.
  a_head_stable : assert property (@(posedge clk) disable iff (!reset)
    (out_valid && !out_ready && !flush) |=> $stable(head));

  a_count_bound : assert property (@(posedge clk) disable iff (!reset)
    count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_m_wb_stage_buffer.sv
// Self-checking bench: DEPTH=2 and DEPTH=4 instances checked against a queue scoreboard.
// Latency: model expects entries one cycle after push.
// Backpressure: model derives in_ready/out_valid/count from its own occupancy.
module tb_m_wb_stage_buffer;
  import m_wb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DEPTH=2 instance signals
  logic          i2_vld, i2_rdy, o2_vld, o2_rdy, fl2;
  m_wb_payload_t i2_p, o2_p;
  logic [1:0]    cnt2;
  // DEPTH=4 instance signals
  logic          i4_vld, i4_rdy, o4_vld, o4_rdy, fl4;
  m_wb_payload_t i4_p, o4_p;
  logic [2:0]    cnt4;

  m_wb_stage_buffer #(.DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .flush(fl2),
    .in_valid(i2_vld), .in_ready(i2_rdy),
    .in_instruction_type(i2_p.instr_type), .in_pc(i2_p.pc), .in_exception(i2_p.exception),
    .in_virtual_addr_exception(i2_p.vaddr_exc), .in_alu_result(i2_p.alu_result),
    .in_rob_id(i2_p.rob_id),
    .out_valid(o2_vld), .out_ready(o2_rdy),
    .out_instruction_type(o2_p.instr_type), .out_pc(o2_p.pc), .out_exception(o2_p.exception),
    .out_virtual_addr_exception(o2_p.vaddr_exc), .out_alu_result(o2_p.alu_result),
    .out_rob_id(o2_p.rob_id), .count(cnt2)
  );

  m_wb_stage_buffer #(.DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .flush(fl4),
    .in_valid(i4_vld), .in_ready(i4_rdy),
    .in_instruction_type(i4_p.instr_type), .in_pc(i4_p.pc), .in_exception(i4_p.exception),
    .in_virtual_addr_exception(i4_p.vaddr_exc), .in_alu_result(i4_p.alu_result),
    .in_rob_id(i4_p.rob_id),
    .out_valid(o4_vld), .out_ready(o4_rdy),
    .out_instruction_type(o4_p.instr_type), .out_pc(o4_p.pc), .out_exception(o4_p.exception),
    .out_virtual_addr_exception(o4_p.vaddr_exc), .out_alu_result(o4_p.alu_result),
    .out_rob_id(o4_p.rob_id), .count(cnt4)
  );

  int            n_chk  = 0;
  int            n_pass = 0;
  int            n_popped = 0;
  m_wb_payload_t sb_q[$];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic m_wb_payload_t mk(input logic [31:0] pc, input logic [4:0] rob,
                                       input logic exc);
    m_wb_payload_t p;
    p.instr_type = 4'($urandom);
    p.pc         = pc;
    p.exception  = exc;
    p.vaddr_exc  = $urandom;
    p.alu_result = $urandom;
    p.rob_id     = rob;
    return p;
  endfunction

  // Called at posedge+1 with inputs already set. Checks at the negedge, updates the
  // scoreboard for the upcoming edge, and returns at the following posedge+1.
  task automatic cycle(input bit d4, output bit pushed);
    int            depth;
    logic          ov, ir, iv, orr, fl;
    logic [2:0]    cnt;
    m_wb_payload_t op, ip, e;
    bit            can_push;
    @(negedge clk);
    depth = d4 ? 4 : 2;
    if (d4) begin
      ov = o4_vld; ir = i4_rdy; cnt = cnt4; op = o4_p;
      iv = i4_vld; orr = o4_rdy; fl = fl4; ip = i4_p;
    end else begin
      ov = o2_vld; ir = i2_rdy; cnt = {1'b0, cnt2}; op = o2_p;
      iv = i2_vld; orr = o2_rdy; fl = fl2; ip = i2_p;
    end
    chk(d4 ? "in_ready4" : "in_ready2", ir, sb_q.size() != depth);
    chk(d4 ? "out_valid4" : "out_valid2", ov, sb_q.size() != 0);
    chk(d4 ? "count4" : "count2", cnt, sb_q.size());
    pushed   = 1'b0;
    can_push = sb_q.size() < depth;
    if (fl) begin
      sb_q.delete();
    end else begin
      if (orr && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(d4 ? "head4" : "head2", op, e);
        n_popped++;
      end
      if (iv && can_push) begin
        sb_q.push_back(ip);
        pushed = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit            pushed;
    int            idx, guard;
    m_wb_payload_t ents[10];

    // 1. Reset with in_valid held high: nothing latched, all outputs idle.
    reset = 1'b0;
    fl2 = 1'b0; fl4 = 1'b0; o2_rdy = 1'b0; o4_rdy = 1'b0;
    i2_vld = 1'b1; i2_p = mk(32'hDEAD, 5'd1, 1'b1);
    i4_vld = 1'b1; i4_p = mk(32'hBEEF, 5'd2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", o2_vld, 1'b0);
    chk("rst_in_ready", i2_rdy, 1'b1);
    chk("rst_count", cnt2, 2'd0);
    chk("rst_out_pc", o2_p.pc, 32'h0);
    chk("rst_count4", cnt4, 3'd0);
    reset = 1'b1; i2_vld = 1'b0; i4_vld = 1'b0;
    cycle(0, pushed);
    cycle(1, pushed);

    // 2. Streaming through DEPTH=2 with out_ready held high.
    o2_rdy = 1'b1;
    i2_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i2_p = mk(32'h100 + 32'(4 * k), 5'(k), 1'b0);
      cycle(0, pushed);
    end
    i2_vld = 1'b0;
    cycle(0, pushed);
    cycle(0, pushed);

    // 3. Backpressure: three offered with out_ready low, then drain.
    o2_rdy = 1'b0;
    i2_vld = 1'b1;
    i2_p = mk(32'h200, 5'd5, 1'b0); cycle(0, pushed);
    i2_p = mk(32'h204, 5'd6, 1'b0); cycle(0, pushed);
    i2_p = mk(32'h208, 5'd7, 1'b1); cycle(0, pushed);   // full: held off
    cycle(0, pushed);
    o2_rdy = 1'b1;
    guard = 0;
    while (!pushed && guard < 8) begin cycle(0, pushed); guard++; end
    chk("bp_third_accepted", pushed, 1'b1);
    i2_vld = 1'b0;
    repeat (3) cycle(0, pushed);

    // 4. Pointer wrap on DEPTH=4 with random out_ready.
    for (int k = 0; k < 10; k++) ents[k] = mk(32'h1000 + 32'(4 * k), 5'(k + 10), k[0]);
    n_popped = 0;
    idx = 0; guard = 0;
    while (idx < 10 && guard < 300) begin
      i4_vld = ($urandom_range(0, 3) != 0);
      i4_p   = ents[idx];
      o4_rdy = $urandom_range(0, 1);
      cycle(1, pushed);
      if (pushed) idx++;
      guard++;
    end
    chk("wrap_all_pushed", idx, 10);
    i4_vld = 1'b0; o4_rdy = 1'b1;
    repeat (6) cycle(1, pushed);
    chk("wrap_delivered", n_popped, 10);

    // 5. Flush with concurrent push and pop: everything dropped.
    o2_rdy = 1'b0; i2_vld = 1'b1;
    i2_p = mk(32'h300, 5'd3, 1'b0); cycle(0, pushed);
    i2_p = mk(32'h304, 5'd4, 1'b0); cycle(0, pushed);
    fl2 = 1'b1; o2_rdy = 1'b1;
    i2_p = mk(32'h308, 5'd8, 1'b0); cycle(0, pushed);
    fl2 = 1'b0; i2_vld = 1'b0;
    cycle(0, pushed);
    cycle(0, pushed);

    // 6. Async reset while stalled with two exception entries.
    o2_rdy = 1'b0; i2_vld = 1'b1;
    i2_p = mk(32'h400, 5'd9, 1'b1); cycle(0, pushed);
    i2_p = mk(32'h404, 5'd10, 1'b1); cycle(0, pushed);
    i2_vld = 1'b0;
    cycle(0, pushed);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", o2_vld, 1'b0);
    chk("arst_count", cnt2, 2'd0);
    chk("arst_exception", o2_p.exception, 1'b0);
    chk("arst_vaddr", o2_p.vaddr_exc, 32'h0);
    sb_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    cycle(0, pushed);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
